// File: rtl/bsg_mem_link_rr_reassembler.sv
// Far-end round-robin mem link reassembler: gathers N narrow lanes into one ordered
// stream and deals one stream back onto the lanes, each lane buffered by its own FIFO.
module bsg_mem_link_rr_reassembler_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [width_p-1:0] data_o
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;

    assign full_o  = (cnt_q == cnt_w'(els_p));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (enq_i) wr_d = (wr_q == ptr_w'(els_p - 1)) ? '0 : wr_q + ptr_w'(1);
        if (deq_i) rd_d = (rd_q == ptr_w'(els_p - 1)) ? '0 : rd_q + ptr_w'(1);
        if (enq_i && !deq_i)      cnt_d = cnt_q + cnt_w'(1);
        else if (!enq_i && deq_i) cnt_d = cnt_q - cnt_w'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_q[wr_q] <= data_i;
    end

    a_no_enq_full:  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(enq_i && full_o));
    a_no_deq_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(deq_i && empty_o));
endmodule

module bsg_mem_link_rr_reassembler #(
    parameter int width_p     = 32,
    parameter int num_lanes_p = 2,
    parameter int fifo_els_p  = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_lanes_p-1:0]         lanes_v_i,
    input  logic [num_lanes_p*width_p-1:0] lanes_data_i,
    output logic [num_lanes_p-1:0]         lanes_ready_and_o,
    output logic                           single_v_o,
    output logic [width_p-1:0]             single_data_o,
    input  logic                           single_ready_and_i,
    input  logic                           single_v_i,
    input  logic [width_p-1:0]             single_data_i,
    output logic                           single_ready_and_o,
    output logic [num_lanes_p-1:0]         lanes_v_o,
    output logic [num_lanes_p*width_p-1:0] lanes_data_o,
    input  logic [num_lanes_p-1:0]         lanes_ready_and_i
);
    localparam int ptr_w = (num_lanes_p > 1) ? $clog2(num_lanes_p) : 1;
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(num_lanes_p - 1);

    logic                   ready_en_q, ready_en_d;
    logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [num_lanes_p-1:0] g_full, g_empty, g_enq, g_deq;
    logic [num_lanes_p-1:0] s_full, s_empty, s_enq, s_deq;
    logic [width_p-1:0]     g_data [num_lanes_p];

    for (genvar k = 0; k < num_lanes_p; k++) begin : g_lane
        bsg_mem_link_rr_reassembler_fifo #(.width_p(width_p), .els_p(fifo_els_p)) gather_fifo (
            .clk_i(clk_i), .reset_n_i(reset_n_i),
            .enq_i(g_enq[k]), .data_i(lanes_data_i[k*width_p +: width_p]),
            .deq_i(g_deq[k]), .full_o(g_full[k]), .empty_o(g_empty[k]), .data_o(g_data[k])
        );
        bsg_mem_link_rr_reassembler_fifo #(.width_p(width_p), .els_p(fifo_els_p)) scatter_fifo (
            .clk_i(clk_i), .reset_n_i(reset_n_i),
            .enq_i(s_enq[k]), .data_i(single_data_i),
            .deq_i(s_deq[k]), .full_o(s_full[k]), .empty_o(s_empty[k]),
            .data_o(lanes_data_o[k*width_p +: width_p])
        );
    end

    // Readies are held low until the first edge after reset release.
    always_comb begin
        ready_en_d         = 1'b1;
        lanes_ready_and_o  = '0;
        lanes_v_o          = '0;
        single_v_o         = 1'b0;
        single_data_o      = '0;
        single_ready_and_o = 1'b0;
        g_enq              = '0;
        g_deq              = '0;
        s_enq              = '0;
        s_deq              = '0;
        rd_ptr_d           = rd_ptr_q;
        wr_ptr_d           = wr_ptr_q;
        for (int k = 0; k < num_lanes_p; k++) begin
            lanes_ready_and_o[k] = ready_en_q & ~g_full[k];
            g_enq[k]             = lanes_v_i[k] & ready_en_q & ~g_full[k];
            lanes_v_o[k]         = ~s_empty[k];
            s_deq[k]             = ~s_empty[k] & lanes_ready_and_i[k];
            if (rd_ptr_q == ptr_w'(k)) begin
                single_v_o    = ~g_empty[k];
                single_data_o = g_data[k];
            end
            if (wr_ptr_q == ptr_w'(k)) single_ready_and_o = ready_en_q & ~s_full[k];
        end
        for (int k = 0; k < num_lanes_p; k++) begin
            g_deq[k] = single_v_o & single_ready_and_i & (rd_ptr_q == ptr_w'(k));
            s_enq[k] = single_v_i & single_ready_and_o & (wr_ptr_q == ptr_w'(k));
        end
        if (single_v_o && single_ready_and_i)
            rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_w'(1);
        if (single_v_i && single_ready_and_o)
            wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_w'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    a_ptr_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (int'(rd_ptr_q) < num_lanes_p) && (int'(wr_ptr_q) < num_lanes_p));
endmodule

// File: tb/tb_bsg_mem_link_rr_reassembler.sv
// Scoreboard bench: N=2 instance for gather ordering/skew/backpressure/reset,
// N=3 instance for scatter dealing, N=1 instance for FIFO simultaneous enq/deq.
module tb_bsg_mem_link_rr_reassembler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=2
    logic [1:0]  g2_lv_i = '0;
    logic [63:0] g2_ld_i = '0;
    logic [1:0]  g2_lr_o;
    logic        g2_sv_o;
    logic [31:0] g2_sd_o;
    logic        g2_sr_i = 1'b1;
    logic        s2_sv_i = 1'b0;
    logic [31:0] s2_sd_i = '0;
    logic        s2_sr_o;
    logic [1:0]  s2_lv_o;
    logic [63:0] s2_ld_o;
    logic [1:0]  s2_lr_i = 2'b11;
    // N=3
    logic [2:0]  g3_lv_i = '0;
    logic [95:0] g3_ld_i = '0;
    logic [2:0]  g3_lr_o;
    logic        g3_sv_o;
    logic [31:0] g3_sd_o;
    logic        g3_sr_i = 1'b1;
    logic        s3_sv_i = 1'b0;
    logic [31:0] s3_sd_i = '0;
    logic        s3_sr_o;
    logic [2:0]  s3_lv_o;
    logic [95:0] s3_ld_o;
    logic [2:0]  s3_lr_i = 3'b111;
    // N=1
    logic [0:0]  g1_lv_i = '0;
    logic [31:0] g1_ld_i = '0;
    logic [0:0]  g1_lr_o;
    logic        g1_sv_o;
    logic [31:0] g1_sd_o;
    logic        g1_sr_i = 1'b0;
    logic        s1_sv_i = 1'b0;
    logic [31:0] s1_sd_i = '0;
    logic        s1_sr_o;
    logic [0:0]  s1_lv_o;
    logic [31:0] s1_ld_o;
    logic [0:0]  s1_lr_i = 1'b1;

    bsg_mem_link_rr_reassembler #(.width_p(32), .num_lanes_p(2), .fifo_els_p(2)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n),
        .lanes_v_i(g2_lv_i), .lanes_data_i(g2_ld_i), .lanes_ready_and_o(g2_lr_o),
        .single_v_o(g2_sv_o), .single_data_o(g2_sd_o), .single_ready_and_i(g2_sr_i),
        .single_v_i(s2_sv_i), .single_data_i(s2_sd_i), .single_ready_and_o(s2_sr_o),
        .lanes_v_o(s2_lv_o), .lanes_data_o(s2_ld_o), .lanes_ready_and_i(s2_lr_i));

    bsg_mem_link_rr_reassembler #(.width_p(32), .num_lanes_p(3), .fifo_els_p(2)) dut3 (
        .clk_i(clk), .reset_n_i(rst_n),
        .lanes_v_i(g3_lv_i), .lanes_data_i(g3_ld_i), .lanes_ready_and_o(g3_lr_o),
        .single_v_o(g3_sv_o), .single_data_o(g3_sd_o), .single_ready_and_i(g3_sr_i),
        .single_v_i(s3_sv_i), .single_data_i(s3_sd_i), .single_ready_and_o(s3_sr_o),
        .lanes_v_o(s3_lv_o), .lanes_data_o(s3_ld_o), .lanes_ready_and_i(s3_lr_i));

    bsg_mem_link_rr_reassembler #(.width_p(32), .num_lanes_p(1), .fifo_els_p(2)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n),
        .lanes_v_i(g1_lv_i), .lanes_data_i(g1_ld_i), .lanes_ready_and_o(g1_lr_o),
        .single_v_o(g1_sv_o), .single_data_o(g1_sd_o), .single_ready_and_i(g1_sr_i),
        .single_v_i(s1_sv_i), .single_data_i(s1_sd_i), .single_ready_and_o(s1_sr_o),
        .lanes_v_o(s1_lv_o), .lanes_data_o(s1_ld_o), .lanes_ready_and_i(s1_lr_i));

    logic [31:0] exp_g2[$];
    logic [31:0] exp_g1[$];
    logic [31:0] exp_s0[$];
    logic [31:0] exp_s1[$];
    logic [31:0] exp_s2[$];
    int checks = 0;
    int failures = 0;
    int done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
    endtask

    task automatic g2_push(input int lane, input logic [31:0] d);
        int n = 0;
        g2_lv_i[lane] = 1'b1;
        g2_ld_i[lane*32 +: 32] = d;
        @(negedge clk);
        while (!g2_lr_o[lane] && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) fail_now("g2_push_timeout", d);
        @(posedge clk); #1;
        g2_lv_i[lane] = 1'b0;
    endtask

    task automatic s3_push(input logic [31:0] d);
        int n = 0;
        s3_sv_i = 1'b1;
        s3_sd_i = d;
        @(negedge clk);
        while (!s3_sr_o && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) fail_now("s3_push_timeout", d);
        @(posedge clk); #1;
        s3_sv_i = 1'b0;
    endtask

    task automatic g1_push(input logic [31:0] d);
        int n = 0;
        g1_lv_i[0] = 1'b1;
        g1_ld_i = d;
        @(negedge clk);
        while (!g1_lr_o[0] && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) fail_now("g1_push_timeout", d);
        @(posedge clk); #1;
        g1_lv_i[0] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_g2.size() + exp_g1.size() + exp_s0.size() + exp_s1.size() + exp_s2.size()) != 0
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now(name, 32'(exp_g2.size() + exp_g1.size() + exp_s0.size()
                                        + exp_s1.size() + exp_s2.size()));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Monitor: pops the expected word whenever a DUT output handshake occurs.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (g2_sv_o && g2_sr_i) begin
                        if (exp_g2.size() == 0) fail_now("g2_extra", g2_sd_o);
                        else chk("g2_data", g2_sd_o, exp_g2.pop_front());
                    end
                    if (g1_sv_o && g1_sr_i) begin
                        if (exp_g1.size() == 0) fail_now("g1_extra", g1_sd_o);
                        else chk("g1_data", g1_sd_o, exp_g1.pop_front());
                    end
                    if (s3_lv_o[0] && s3_lr_i[0]) begin
                        if (exp_s0.size() == 0) fail_now("s3_lane0_extra", s3_ld_o[31:0]);
                        else chk("s3_lane0", s3_ld_o[31:0], exp_s0.pop_front());
                    end
                    if (s3_lv_o[1] && s3_lr_i[1]) begin
                        if (exp_s1.size() == 0) fail_now("s3_lane1_extra", s3_ld_o[63:32]);
                        else chk("s3_lane1", s3_ld_o[63:32], exp_s1.pop_front());
                    end
                    if (s3_lv_o[2] && s3_lr_i[2]) begin
                        if (exp_s2.size() == 0) fail_now("s3_lane2_extra", s3_ld_o[95:64]);
                        else chk("s3_lane2", s3_ld_o[95:64], exp_s2.pop_front());
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_g2_ready", 32'(g2_lr_o), 32'h0);
        chk("rst_g2_v", 32'(g2_sv_o), 32'h0);
        chk("rst_s3_ready", 32'(s3_sr_o), 32'h0);
        chk("rst_s3_lanes_v", 32'(s3_lv_o), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_still_low", 32'(g2_lr_o), 32'h0);
        @(negedge clk);
        chk("rel_g2_ready_up", 32'(g2_lr_o), 32'h3);
        chk("rel_s3_ready_up", 32'(s3_sr_o), 32'h1);
        @(posedge clk); #1;

        // T1 order
        exp_g2.push_back(32'hA0); exp_g2.push_back(32'hB0);
        exp_g2.push_back(32'hA1); exp_g2.push_back(32'hB1);
        fork
            begin g2_push(0, 32'hA0); g2_push(0, 32'hA1); end
            begin g2_push(1, 32'hB0); g2_push(1, 32'hB1); end
        join
        drain("t1_drain_timeout");

        // T2 skew: lane1 early, lane0 late; lane1 must wait behind lane0
        exp_g2.push_back(32'h22); exp_g2.push_back(32'h11);
        for (int c = 0; c < 12; c++) begin
            g2_lv_i = 2'b00;
            if (c == 3) begin g2_lv_i[1] = 1'b1; g2_ld_i[63:32] = 32'h11; end
            if (c == 8) begin g2_lv_i[0] = 1'b1; g2_ld_i[31:0]  = 32'h22; end
            @(negedge clk);
            chk($sformatf("t2_v_c%0d", c), 32'(g2_sv_o), (c == 9 || c == 10) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        g2_lv_i = 2'b00;
        drain("t2_drain_timeout");

        // T3 backpressure
        g2_sr_i = 1'b0;
        done = 0;
        for (int i = 0; i < 4; i++) begin
            exp_g2.push_back(32'h30 + 32'(i));
            exp_g2.push_back(32'h40 + 32'(i));
        end
        fork
            begin for (int i = 0; i < 4; i++) g2_push(0, 32'h30 + 32'(i)); done++; end
            begin for (int i = 0; i < 4; i++) g2_push(1, 32'h40 + 32'(i)); done++; end
        join_none
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 6) begin
                chk("t3_lane_ready_low", 32'(g2_lr_o), 32'h0);
                chk("t3_head_v", 32'(g2_sv_o), 32'h1);
                chk("t3_head_data", g2_sd_o, 32'h30);
            end
        end
        @(posedge clk); #1;
        g2_sr_i = 1'b1;
        for (int n = 0; n < 100 && done < 2; n++) @(posedge clk);
        #1;
        if (done < 2) fail_now("t3_push_timeout", 32'(done));
        drain("t3_drain_timeout");

        // T5 reset mid-stream with rd_ptr parked on lane1
        exp_g2.push_back(32'h5F);
        g2_push(0, 32'h5F);
        drain("t5_pre_drain_timeout");
        g2_sr_i = 1'b0;
        g2_push(1, 32'h60);
        g2_push(0, 32'h50);
        g2_push(1, 32'h61);
        @(negedge clk);
        chk("t5_pre_v", 32'(g2_sv_o), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_g2_v", 32'(g2_sv_o), 32'h0);
        chk("t5_rst_g2_ready", 32'(g2_lr_o), 32'h0);
        chk("t5_rst_s3_ready", 32'(s3_sr_o), 32'h0);
        chk("t5_rst_g1_ready", 32'(g1_lr_o), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        g2_sr_i = 1'b1;
        exp_g2.push_back(32'h71); exp_g2.push_back(32'h70);
        g2_push(1, 32'h70);
        g2_push(0, 32'h71);
        drain("t5_drain_timeout");

        // T4 scatter, N=3
        for (int i = 0; i < 2; i++) begin
            exp_s0.push_back(32'h1 + 32'(3*i));
            exp_s1.push_back(32'h2 + 32'(3*i));
            exp_s2.push_back(32'h3 + 32'(3*i));
        end
        for (int i = 1; i <= 6; i++) s3_push(32'(i));
        drain("t4_drain_timeout");
        s3_lr_i = 3'b011;
        for (int i = 0; i < 3; i++) begin
            exp_s0.push_back(32'h7 + 32'(3*i));
            exp_s1.push_back(32'h8 + 32'(3*i));
            exp_s2.push_back(32'h9 + 32'(3*i));
        end
        for (int i = 7; i <= 14; i++) s3_push(32'(i));
        s3_sv_i = 1'b1;
        s3_sd_i = 32'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_ready_low_lane2_full", 32'(s3_sr_o), 32'h0);
        end
        chk("t4_lane2_v", 32'(s3_lv_o[2]), 32'h1);
        @(posedge clk); #1;
        s3_lr_i = 3'b111;
        s3_push(32'hF);
        drain("t4b_drain_timeout");

        // T6 simultaneous enqueue/dequeue, N=1
        exp_g1.push_back(32'hA1); exp_g1.push_back(32'hA2); exp_g1.push_back(32'hA3);
        g1_push(32'hA1);
        g1_lv_i[0] = 1'b1; g1_ld_i = 32'hA2; g1_sr_i = 1'b1;
        @(negedge clk);
        chk("t6_simul_ready", 32'(g1_lr_o), 32'h1);
        @(posedge clk); #1;
        g1_lv_i[0] = 1'b0; g1_sr_i = 1'b0;
        @(negedge clk);
        chk("t6_cnt1_v", 32'(g1_sv_o), 32'h1);
        chk("t6_cnt1_not_full", 32'(g1_lr_o), 32'h1);
        @(posedge clk); #1;
        g1_push(32'hA3);
        @(negedge clk);
        chk("t6_full_ready", 32'(g1_lr_o), 32'h0);
        @(posedge clk); #1;
        g1_lv_i[0] = 1'b1; g1_ld_i = 32'hA4; g1_sr_i = 1'b1;
        @(negedge clk);
        chk("t6_full_simul_ready", 32'(g1_lr_o), 32'h0);
        @(posedge clk); #1;
        g1_lv_i[0] = 1'b0;
        drain("t6_drain_timeout");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_refused_word_absent", 32'(g1_sv_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
